// File: rtl/mcu_key_in.sv
// Avalon-MM input PIO: synchronised, debounced pins with sticky edge capture
// and a masked level interrupt to the CPU.
module mcu_key_in #(
    parameter int               WIDTH            = 4,
    parameter int               EDGE_TYPE        = 1,
    parameter int               DEBOUNCE_BITS    = 16,
    parameter int               DEBOUNCE_DEFAULT = 50000,
    parameter logic [WIDTH-1:0] IN_RESET_VALUE   = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0]         sync1;
    logic [WIDTH-1:0]         sync2;
    logic [WIDTH-1:0]         deb;
    logic [WIDTH-1:0]         mask;
    logic [WIDTH-1:0]         edge_cap;
    logic [DEBOUNCE_BITS-1:0] reload;
    logic [DEBOUNCE_BITS-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clr;
    logic             wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // load marks the cycle a bit's debounced level takes the new value
    always_comb begin
        load = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load[i] = (sync2[i] != deb[i]) && (cnt[i] >= reload);
        end
    end

    assign rise   = load & sync2 & ~deb;
    assign fall   = load & ~sync2 & deb;
    assign detect = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);
    assign clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0]         = deb;
            2'd1: rd_mux[DEBOUNCE_BITS-1:0] = reload;
            2'd2: rd_mux[WIDTH-1:0]         = mask;
            2'd3: rd_mux[WIDTH-1:0]         = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VALUE;
            sync2 <= IN_RESET_VALUE;
            deb   <= IN_RESET_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            deb   <= (deb & ~load) | (sync2 & load);
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == deb[i] || load[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEBOUNCE_BITS'(1);
                end
            end
        end
    end

    // set beats clear so an edge landing on the clearing write is not lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload   <= DEBOUNCE_BITS'(DEBOUNCE_DEFAULT);
            mask     <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr && address == 2'd1) begin
                reload <= writedata[DEBOUNCE_BITS-1:0];
            end
            if (wr && address == 2'd2) begin
                mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~clr) | detect;
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & mask);

endmodule

// File: tb/tb_mcu_key_in.sv
// Directed bench for mcu_key_in: a falling-edge instance and an
// any-edge instance sharing the register bus.
module tb_mcu_key_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;
    logic [31:0] readdata_b;
    logic [3:0]  in_port_b;
    logic        irq_b;

    int n_cmp  = 0;
    int n_fail = 0;

    mcu_key_in #(.EDGE_TYPE(1)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    mcu_key_in #(.EDGE_TYPE(2)) u_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_b),
        .in_port    (in_port_b),
        .irq        (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_port = 4'b0101;
        repeat (3) tick();
        if (readdata !== 32'h0) begin
            $display("FAIL rst_rdata: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL rst_irq: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
        reset_n = 1'b1;
        tick();
        if (readdata !== 32'hF) begin
            $display("FAIL rst_data_hi: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        repeat (50002) tick();
        if (readdata !== 32'hF) begin
            $display("FAIL rst_data_pre: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        tick();
        if (readdata !== 32'h5) begin
            $display("FAIL rst_data_post: got %h want %h", readdata, 32'h5);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'hA) begin
            $display("FAIL rst_capture: got %h want %h", readdata, 32'hA);
            n_fail++;
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL rst_irq_masked: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_debounce();
        bus_wr(2'd1, 32'd10);
        in_port = 4'hF;
        repeat (20) tick();
        bus_wr(2'd3, 32'hF);
        rd(2'd1);
        if (readdata !== 32'd10) begin
            $display("FAIL db_reload: got %h want %h", readdata, 32'd10);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'h0) begin
            $display("FAIL db_cleared: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        address = 2'd0;
        tick();
        in_port = 4'hE;
        repeat (8) tick();
        in_port = 4'hF;
        repeat (20) tick();
        if (readdata !== 32'hF) begin
            $display("FAIL db_glitch_data: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'h0) begin
            $display("FAIL db_glitch_cap: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        address = 2'd0;
        tick();
        in_port = 4'hE;
        repeat (13) tick();
        if (readdata !== 32'hF) begin
            $display("FAIL db_hold_early: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        tick();
        if (readdata !== 32'hE) begin
            $display("FAIL db_hold_data: got %h want %h", readdata, 32'hE);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'h1) begin
            $display("FAIL db_hold_cap: got %h want %h", readdata, 32'h1);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_irq();
        in_port = 4'hF;
        repeat (15) tick();
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'h1);
        if (irq !== 1'b0) begin
            $display("FAIL irq_idle: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
        in_port = 4'hE;
        repeat (12) tick();
        if (irq !== 1'b0) begin
            $display("FAIL irq_early: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
        tick();
        if (irq !== 1'b1) begin
            $display("FAIL irq_set: got %b want 1", irq);
            n_fail++;
        end
        n_cmp++;
        bus_wr(2'd3, 32'h1);
        if (irq !== 1'b0) begin
            $display("FAIL irq_clear: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
        in_port = 4'hA;
        repeat (15) tick();
        rd(2'd3);
        if (readdata !== 32'h4) begin
            $display("FAIL irq_cap_bit2: got %h want %h", readdata, 32'h4);
            n_fail++;
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_unmasked: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_clear_collision();
        in_port = 4'hF;
        repeat (15) tick();
        bus_wr(2'd3, 32'hF);
        rd(2'd3);
        if (readdata !== 32'h0) begin
            $display("FAIL col_no_rise: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        in_port = 4'hE;
        repeat (12) tick();
        if (irq !== 1'b0) begin
            $display("FAIL col_early: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
        bus_wr(2'd3, 32'h1);
        if (irq !== 1'b1) begin
            $display("FAIL col_irq: got %b want 1", irq);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'h1) begin
            $display("FAIL col_cap: got %h want %h", readdata, 32'h1);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reload0();
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd3, 32'hF);
        address = 2'd0;
        tick();
        in_port = 4'hF;
        repeat (3) tick();
        if (readdata !== 32'hE) begin
            $display("FAIL r0_early: got %h want %h", readdata, 32'hE);
            n_fail++;
        end
        n_cmp++;
        tick();
        if (readdata !== 32'hF) begin
            $display("FAIL r0_follow: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        in_port_b = 4'hE;
        repeat (5) tick();
        rd(2'd3);
        if (readdata_b !== 32'h1) begin
            $display("FAIL any_fall: got %h want %h", readdata_b, 32'h1);
            n_fail++;
        end
        n_cmp++;
        if (irq_b !== 1'b1) begin
            $display("FAIL any_irq: got %b want 1", irq_b);
            n_fail++;
        end
        n_cmp++;
        bus_wr(2'd3, 32'hF);
        in_port_b = 4'hF;
        repeat (5) tick();
        rd(2'd3);
        if (readdata_b !== 32'h1) begin
            $display("FAIL any_rise: got %h want %h", readdata_b, 32'h1);
            n_fail++;
        end
        n_cmp++;
        if (readdata !== 32'h0) begin
            $display("FAIL fall_only: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        bus_wr(2'd0, 32'h0);
        rd(2'd0);
        if (readdata !== 32'hF) begin
            $display("FAIL data_ro: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_midcount();
        bus_wr(2'd1, 32'd100);
        bus_wr(2'd2, 32'hF);
        in_port = 4'h0;
        repeat (49) tick();
        rd(2'd1);
        if (readdata !== 32'd100) begin
            $display("FAIL mid_reload: got %h want %h", readdata, 32'd100);
            n_fail++;
        end
        n_cmp++;
        reset_n = 1'b0;
        #1;
        if (readdata !== 32'h0) begin
            $display("FAIL mid_rdata: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        in_port = 4'hF;
        repeat (3) tick();
        reset_n = 1'b1;
        rd(2'd1);
        if (readdata !== 32'd50000) begin
            $display("FAIL mid_reload_def: got %h want %h", readdata, 32'd50000);
            n_fail++;
        end
        n_cmp++;
        rd(2'd2);
        if (readdata !== 32'h0) begin
            $display("FAIL mid_mask: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        rd(2'd3);
        if (readdata !== 32'h0) begin
            $display("FAIL mid_cap: got %h want %h", readdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        rd(2'd0);
        if (readdata !== 32'hF) begin
            $display("FAIL mid_data: got %h want %h", readdata, 32'hF);
            n_fail++;
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL mid_irq: got %b want 0", irq);
            n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        in_port_b  = 4'hF;
        test_reset();
        test_debounce();
        test_irq();
        test_clear_collision();
        test_reload0();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_key_in.md
# mcu_key_in

Avalon-MM slave input port: the read-side counterpart of the LED output PIO in the mcu Qsys system. It samples WIDTH external pins (push-buttons/switches), synchronises and debounces them, latches the selected edges into a sticky edge-capture register, and raises a level interrupt to the Nios II through a per-bit mask. The CPU reads levels, configures debounce and mask, and clears captured edges over the same 2-bit-address register bus used by the output PIO.

## Interface
- WIDTH, 4: number of input pins (1..32).
- EDGE_TYPE, 1: captured edge; 0 rising, 1 falling, 2 any.
- DEBOUNCE_BITS, 16: width of debounce reload and per-bit counters (1..32).
- DEBOUNCE_DEFAULT, 50000: reset value of the debounce reload register (1 ms at 50 MHz).
- IN_RESET_VALUE, all ones: reset value of the synchroniser and debounced-level registers (WIDTH bits).

- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data; unused upper bits 0.
- in_port  in  WIDTH  asynchronous external pins.
- irq  out  1  level interrupt, active high.

## Operation
- Register map: 0 data (RO, debounced level, writes ignored); 1 debounce reload (RW, bits [DEBOUNCE_BITS-1:0]); 2 irq mask (RW, bits [WIDTH-1:0]); 3 edge capture (read; write-1-to-clear per bit).
- Write occurs when chipselect && !write_n at a rising clk edge.
- Input path per bit: two-flop synchroniser (sync1, sync2) -> debouncer -> deb register.
- Debouncer per bit: counter cleared to 0 whenever sync2 == deb. While sync2 != deb: if counter >= reload then deb <= sync2 and counter <= 0, else counter increments. Reload 0 means no filtering. Comparison is >= so lowering reload mid-count takes effect immediately. Counter never wraps.
- Edge detect: asserted for bit i in the cycle deb[i] updates: rising = 0->1, falling = 1->0, any = either, per EDGE_TYPE.
- Edge capture bit is sticky: set on detect, cleared only by a write to address 3 with writedata[i]=1. Detect and clear in the same cycle: set wins, bit stays 1.
- irq = |(edgecapture & mask), combinational from registers (no extra flop).
- Reset: sync1, sync2, deb = IN_RESET_VALUE; counters 0; reload = DEBOUNCE_DEFAULT; mask 0; edgecapture 0; readdata 0; irq 0. No edge is detected on reset release unless pins differ from IN_RESET_VALUE, in which case the normal debounce path applies.

## Timing
- readdata registered every cycle from address, independent of chipselect: read latency 1 (valid the cycle after address is presented). No wait states.
- Pin change sampled at edge k: sync2 valid at k+1, deb and edgecapture updated at edge k+2+reload, irq high the same cycle if masked in.
- A glitch shorter than reload+1 consecutive sync2 cycles never changes deb.
- Register writes take effect at the write edge and are readable via readdata one edge later. Mask write affects irq in the same cycle the register updates.
- Reset assertion mid-debounce or mid-transfer aborts immediately, all state to reset values.

## Test plan
- Reset: hold reset_n low with in_port=4'b0101; release -> readdata 0, irq 0; reading address 0 returns 0xF until reload (50000) cycles elapse, then 0x5; edgecapture = 0xA (falling on bits 1,3).
- Debounce: set reload=10, bit 0 drops for 8 cycles then returns -> data and capture unchanged; hold low for 12+ cycles -> data bit 0 = 0 exactly at edge k+12, capture bit 0 = 1.
- Interrupt: mask=0x1, falling edge on bit 0 -> irq=1; write 0x1 to address 3 -> irq=0 next cycle; edge on bit 2 with mask 0x1 -> capture 0x4, irq stays 0.
- Clear collision: write 0x1 to address 3 in the same cycle bit 0 edge is detected -> capture bit 0 remains 1, irq stays 1.
- Reload=0: bit toggle -> deb follows in 2 cycles; EDGE_TYPE=2 build captures both rising and falling; address 0 write ignored.
- Reset mid-count: reload=100, pin changes, reset_n pulsed at cycle 50 -> all registers to reset values, reload back to DEBOUNCE_DEFAULT.
